vproc_div_seq: RTL and testbench

- Sequential controller plus iterative datapath that runs one scalar or element division at a time for the vector unit's DIV/DIVU/REM/REMU paths.
- Accepts one operand pair over a valid/ready request channel. Runs a radix-2 restoring division, one bit per cycle.
- Resolves special cases early and returns the result over a valid/ready response channel with the requester's tag.
- Sits between the vector element sequencer and the result writeback.

---
 rtl/vproc_div_seq.sv | 208 ++++++++++++++++++++
 tb/tb_vproc_div_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_div_seq.sv
// vproc_div_seq
// Sequential radix-2 restoring divider for the vector unit's DIV/DIVU/REM/REMU
// paths. One operand pair is accepted over a valid/ready request channel, one
// quotient bit is produced per cycle, and the quotient or remainder is returned
// over a valid/ready response channel together with the requester's tag.
// Divide-by-zero and signed overflow follow RISC-V semantics. With EARLY_OUT set
// they skip the iteration and respond one cycle after the handshake.
//
// Ports
//   clk_i, async_rst_ni      clock, asynchronous active-low reset
//   flush_i                  synchronous abort; returns to IDLE, drops any result
//   req_valid_i/req_ready_o  request handshake
//   req_op1_i, req_op2_i     dividend, divisor
//   req_mod_i                0 = quotient, 1 = remainder
//   req_signed_i             1 = signed operands
//   req_id_i                 tag returned with the result
//   res_valid_o/res_ready_i  response handshake
//   res_o, res_id_o          result and its tag, held while DONE
//   busy_o                   high whenever not IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request
// PREP  | take absolute values, record result signs, arm the bit counter
// ITER  | one restoring-division step per cycle, OP_W cycles
// FIX   | apply result signs, select quotient/remainder, force specials
// DONE  | result presented until res_ready_i
module vproc_div_seq #(
  parameter int unsigned OP_W      = 32,
  parameter int unsigned ID_W      = 4,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            async_rst_ni,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [OP_W-1:0] req_op1_i,
  input  logic [OP_W-1:0] req_op2_i,
  input  logic            req_mod_i,
  input  logic            req_signed_i,
  input  logic [ID_W-1:0] req_id_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [OP_W-1:0] res_o,
  output logic [ID_W-1:0] res_id_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(OP_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [OP_W-1:0]  MIN_NEG  = {1'b1, {(OP_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OP_W-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  // dvd_q holds the dividend and collects quotient bits from the LSB as the
  // dividend bits are shifted out of the MSB.
  logic [OP_W-1:0]  dvd_q, dvd_d;
  logic [OP_W-1:0]  dvs_q, dvs_d;
  logic [OP_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mod_q, mod_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             spec_q, spec_d;
  logic [OP_W-1:0]  spec_res_q, spec_res_d;
  logic [OP_W-1:0]  res_q, res_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic             req_div0, req_ovf, req_spec, accept;
  logic [OP_W-1:0]  req_spec_res;
  logic [OP_W+1:0]  rem_sh;
  logic [OP_W:0]    rem_sub;
  logic             rem_ge;
  logic [OP_W-1:0]  q_fix, r_fix;

  assign req_div0     = (req_op2_i == '0);
  assign req_ovf      = req_signed_i && (req_op1_i == MIN_NEG) && (req_op2_i == '1);
  assign req_spec     = req_div0 || req_ovf;
  assign req_spec_res = req_div0 ? (req_mod_i ? req_op1_i : '1)
                                 : (req_mod_i ? '0 : req_op1_i);

  assign accept = (state_q == S_IDLE) && req_valid_i && !flush_i;

  // rem_q[OP_W] is always 0 between steps; carrying it into the compare keeps
  // the OP_W+1-bit shifted remainder comparison exact.
  assign rem_sh  = {rem_q, dvd_q[OP_W-1]};
  assign rem_ge  = (rem_sh >= {2'b00, dvs_q});
  assign rem_sub = rem_sh[OP_W:0] - {1'b0, dvs_q};

  assign q_fix = qneg_q ? -dvd_q : dvd_q;
  assign r_fix = rneg_q ? -rem_q[OP_W-1:0] : rem_q[OP_W-1:0];

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    mod_d      = mod_q;
    sgn_d      = sgn_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    res_d      = res_q;
    id_d       = id_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dvd_d      = req_op1_i;
          dvs_d      = req_op2_i;
          mod_d      = req_mod_i;
          sgn_d      = req_signed_i;
          id_d       = req_id_i;
          spec_d     = req_spec;
          spec_res_d = req_spec_res;
          if (EARLY_OUT && req_spec) begin
            res_d   = req_spec_res;
            state_d = S_DONE;
          end else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        qneg_d = sgn_q && (dvd_q[OP_W-1] ^ dvs_q[OP_W-1]);
        rneg_d = sgn_q && dvd_q[OP_W-1];
        if (sgn_q && dvd_q[OP_W-1]) dvd_d = -dvd_q;
        if (sgn_q && dvs_q[OP_W-1]) dvs_d = -dvs_q;
        rem_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (rem_ge) begin
          rem_d = rem_sub;
          dvd_d = {dvd_q[OP_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[OP_W:0];
          dvd_d = {dvd_q[OP_W-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_FIX: begin
        if (spec_q)     res_d = spec_res_q;
        else if (mod_q) res_d = r_fix;
        else            res_d = q_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q    <= S_IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      mod_q      <= 1'b0;
      sgn_q      <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      res_q      <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      mod_q      <= mod_d;
      sgn_q      <= sgn_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      res_q      <= res_d;
      id_q       <= id_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE) && !flush_i;
  assign res_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign res_o       = res_q;
  assign res_id_o    = id_q;

endmodule

// File: tb/tb_vproc_div_seq.sv
module tb_vproc_div_seq;

  localparam int unsigned OP_W = 32;
  localparam int unsigned ID_W = 4;
  localparam int unsigned LAT  = OP_W + 3;

  logic            clk_i = 1'b0;
  logic            async_rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            req_valid_i = 1'b0;
  logic [OP_W-1:0] req_op1_i = '0, req_op2_i = '0;
  logic            req_mod_i = 1'b0, req_signed_i = 1'b0;
  logic [ID_W-1:0] req_id_i = '0;
  logic            res_ready_i;
  logic            req_ready_o, res_valid_o, busy_o;
  logic [OP_W-1:0] res_o;
  logic [ID_W-1:0] res_id_o;

  // second instance without early-out, driven separately
  logic            b_valid = 1'b0;
  logic [OP_W-1:0] b_op1 = '0, b_op2 = '0;
  logic            b_mod = 1'b0;
  logic            b_req_ready, b_res_valid, b_busy;
  logic [OP_W-1:0] b_res;
  logic [ID_W-1:0] b_res_id;

  logic bp_en = 1'b0, ready_dir = 1'b1, rnd_ready = 1'b1;
  assign res_ready_i = bp_en ? rnd_ready : ready_dir;

  vproc_div_seq #(.OP_W(OP_W), .ID_W(ID_W), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_mod_i(req_mod_i),
    .req_signed_i(req_signed_i), .req_id_i(req_id_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_id_o(res_id_o), .busy_o(busy_o)
  );

  vproc_div_seq #(.OP_W(OP_W), .ID_W(ID_W), .EARLY_OUT(1'b0)) dut_b (
    .clk_i(clk_i), .async_rst_ni(async_rst_ni), .flush_i(1'b0),
    .req_valid_i(b_valid), .req_ready_o(b_req_ready),
    .req_op1_i(b_op1), .req_op2_i(b_op2), .req_mod_i(b_mod),
    .req_signed_i(1'b1), .req_id_i(4'd7),
    .res_valid_o(b_res_valid), .res_ready_i(1'b1),
    .res_o(b_res), .res_id_o(b_res_id), .busy_o(b_busy)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [OP_W-1:0] res;
    logic [ID_W-1:0] id;
    int unsigned     hs;
    int unsigned     lat;
  } exp_t;
  exp_t sb[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // RISC-V division from plain integer arithmetic; 64-bit intermediates make
  // signed overflow wrap naturally to the architectural result.
  function automatic logic [OP_W-1:0] model(input logic [OP_W-1:0] a, b, input logic m, s);
    longint sa, sbv;
    if (b == '0) return m ? a : '1;
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return m ? OP_W'(sa % sbv) : OP_W'(sa / sbv);
    end
    return m ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [OP_W-1:0] a, b, input logic s);
    return (b == '0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic send(input logic [OP_W-1:0] a, b, input logic m, s,
                      input logic [ID_W-1:0] id, input bit push, output int unsigned hs);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op1_i = a; req_op2_i = b;
    req_mod_i = m; req_signed_i = s; req_id_i = id;
    while (!req_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL req_handshake_timeout: actual no ready required ready within 300 cycles");
    end
    @(posedge clk_i);
    #1;
    hs = cyc;
    req_valid_i = 1'b0;
    if (push) begin
      e.res = model(a, b, m, s);
      e.id  = id;
      e.hs  = hs;
      e.lat = is_special(a, b, s) ? 1 : LAT;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_timeout", {63'd0, (n >= 1000)}, 64'd0);
  endtask

  task automatic run_b(input logic [OP_W-1:0] a, b, input logic m, input string name);
    int unsigned hs;
    int n;
    @(negedge clk_i);
    b_valid = 1'b1; b_op1 = a; b_op2 = b; b_mod = m;
    @(posedge clk_i);
    #1;
    hs = cyc;
    b_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!b_res_valid && n < 100);
    chk({name, "_valid"}, {63'd0, b_res_valid}, 64'd1);
    chk({name, "_value"}, {32'd0, b_res}, {32'd0, model(a, b, m, 1'b1)});
    chk({name, "_latency"}, 64'(cyc - hs + 1), 64'(LAT));
  endtask

  always @(negedge clk_i) rnd_ready <= ($urandom_range(0, 3) != 0);

  // monitor / scoreboard
  initial begin
    bit seen;
    exp_t e;
    logic [OP_W-1:0] held_res;
    logic [ID_W-1:0] held_id;
    seen = 1'b0; held_res = '0; held_id = '0;
    forever begin
      @(negedge clk_i);
      if (!async_rst_ni || !res_valid_o) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        held_res = res_o;
        held_id  = res_id_o;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: actual res 0x%0h id %0d required no response", res_o, res_id_o);
        end else begin
          e = sb.pop_front();
          chk("res_value", {32'd0, res_o}, {32'd0, e.res});
          chk("res_id", {60'd0, res_id_o}, {60'd0, e.id});
          chk("res_latency", 64'(cyc - e.hs + 1), 64'(e.lat));
        end
      end else begin
        chk("hold_res", {32'd0, res_o}, {32'd0, held_res});
        chk("hold_id", {60'd0, res_id_o}, {60'd0, held_id});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual still running required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned h1, h2, hs, ack;
    logic [OP_W-1:0] a, b;
    int r;

    // reset
    #12;
    chk("rst_valid", {63'd0, res_valid_o}, 64'd0);
    chk("rst_res", {32'd0, res_o}, 64'd0);
    chk("rst_id", {60'd0, res_id_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);

    // directed values, no backpressure
    send(32'd100, 32'd7, 1'b0, 1'b0, 4'd5, 1'b1, h1);
    send(32'd100, 32'd7, 1'b1, 1'b0, 4'd6, 1'b1, h2);
    chk("throughput", 64'(h2 - h1), 64'(LAT + 1));
    send(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 4'd1, 1'b1, hs);
    send(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 4'd2, 1'b1, hs);
    send(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 4'd3, 1'b1, hs);
    send(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 4'd4, 1'b1, hs);
    send(32'h1234, 32'd0, 1'b0, 1'b1, 4'd8, 1'b1, hs);
    send(32'h1234, 32'd0, 1'b1, 1'b1, 4'd9, 1'b1, hs);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd10, 1'b1, hs);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd11, 1'b1, hs);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd12, 1'b1, hs);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd13, 1'b1, hs);
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd14, 1'b1, hs);
    send(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 4'd15, 1'b1, hs);
    wait_drain();

    // randomized with response backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      b = '0;
      else if (r == 1) begin a = 32'h8000_0000; b = '1; end
      else if (r == 2) b = 32'($urandom_range(1, 15));
      else             b = $urandom >> $urandom_range(0, 31);
      send(a, b, 1'($urandom), 1'($urandom), 4'($urandom), 1'b1, hs);
    end
    wait_drain();
    bp_en = 1'b0;

    // hold in DONE for 10 cycles, then release
    ready_dir = 1'b0;
    send(32'd1000, 32'd3, 1'b0, 1'b0, 4'd9, 1'b1, hs);
    r = 0;
    while (!res_valid_o && r < 100) begin
      @(negedge clk_i);
      r++;
    end
    repeat (10) begin
      @(negedge clk_i);
      chk("bp_valid", {63'd0, res_valid_o}, 64'd1);
      chk("bp_req_ready", {63'd0, req_ready_o}, 64'd0);
      chk("bp_busy", {63'd0, busy_o}, 64'd1);
    end
    ready_dir = 1'b1;
    ack = cyc + 1;
    @(posedge clk_i);
    #1;
    chk("bp_release_idle", {63'd0, busy_o}, 64'd0);
    send(32'd50, 32'd5, 1'b1, 1'b0, 4'd10, 1'b1, hs);
    chk("bp_next_accept", 64'(hs), 64'(ack + 1));
    wait_drain();

    // flush in the 10th ITER cycle, then flush blocks an IDLE request
    send(32'd1000, 32'd3, 1'b0, 1'b0, 4'd2, 1'b0, hs);
    repeat (11) @(negedge clk_i);
    chk("flush_in_iter_cycle", 64'(cyc - hs), 64'd10);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    chk("flush_valid", {63'd0, res_valid_o}, 64'd0);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_op1_i = 32'd9; req_op2_i = 32'd2;
    #1;
    chk("flush_req_ready", {63'd0, req_ready_o}, 64'd0);
    @(posedge clk_i);
    #1;
    chk("flush_no_accept", {63'd0, busy_o}, 64'd0);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b0;
    send(32'd1000, 32'd3, 1'b1, 1'b0, 4'd3, 1'b1, hs);
    wait_drain();

    // flush while DONE with res_ready_i low drops the result
    ready_dir = 1'b0;
    send(32'd5, 32'd0, 1'b0, 1'b0, 4'd6, 1'b1, hs);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("flush_done_valid", {63'd0, res_valid_o}, 64'd0);
    chk("flush_done_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    ready_dir = 1'b1;
    send(32'd77, 32'd10, 1'b0, 1'b1, 4'd4, 1'b1, hs);
    wait_drain();

    // asynchronous reset mid-ITER
    send(32'd123456, 32'd17, 1'b0, 1'b0, 4'd11, 1'b0, hs);
    repeat (6) @(negedge clk_i);
    #2;
    async_rst_ni = 1'b0;
    #1;
    chk("arst_valid", {63'd0, res_valid_o}, 64'd0);
    chk("arst_res", {32'd0, res_o}, 64'd0);
    chk("arst_id", {60'd0, res_id_o}, 64'd0);
    chk("arst_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("arst_req_ready", {63'd0, req_ready_o}, 64'd1);
    send(32'd123456, 32'd17, 1'b1, 1'b0, 4'd12, 1'b1, hs);
    wait_drain();

    // no early-out: specials take the full latency
    run_b(32'h1234, 32'd0, 1'b0, "noeo_div0_q");
    run_b(32'h1234, 32'd0, 1'b1, "noeo_div0_r");
    run_b(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "noeo_ovf_q");
    run_b(32'hFFFF_FFF9, 32'd2, 1'b1, "noeo_signed_r");

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
